// File: rtl/half_predict_sequencer.sv
// ---------------------------------------------------------------------------
// half_predict_sequencer
//
// Top-level controller for the half-precision two-layer predictor datapath.
// A single host beat stream (MULTS fp16 lanes per beat) is steered either to
// the datapath parameter-load strobes (W1, b1, W2, b2 in that order) or to the
// datapath x input during inference. After the last image beat the sequencer
// waits for the datapath out_valid, registers y, scans it for the argmax class
// one element per cycle, and emits a one-cycle result pulse.
//
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   start_load             pulse: begin parameter load (IDLE or READY only)
//   start_infer            pulse: begin one inference (READY only)
//   abort                  synchronous abort, highest priority
//   s_valid/s_data/s_ready host beat stream (transfer = s_valid & s_ready)
//   dp_in_valid, dp_x      image beats to the datapath
//   dp_load_W1/b1/W2/b2    parameter load strobes, dp_neuron_data their data
//   dp_out_valid, dp_y     datapath result vector (OUTPUT_NODES fp16 values)
//   loaded                 full parameter set resident in the datapath
//   busy                   sequencer is neither IDLE nor READY
//   res_valid              one-cycle result pulse
//   res_class, res_value   argmax index and its fp16 value, held between results
//   error                  sticky timeout flag, cleared by start_load or reset
// ---------------------------------------------------------------------------
module half_predict_sequencer #(
   parameter int LAYER1_NEURONS = 784,
   parameter int LAYER2_NEURONS = 50,
   parameter int OUTPUT_NODES   = 10,
   parameter int MULTS          = 2,
   parameter int TIMEOUT        = 65535
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic                              start_load,
   input  logic                              start_infer,
   input  logic                              abort,
   input  logic                              s_valid,
   input  logic [16*MULTS-1:0]               s_data,
   output logic                              s_ready,
   output logic                              dp_in_valid,
   output logic                              dp_load_W1,
   output logic                              dp_load_b1,
   output logic                              dp_load_W2,
   output logic                              dp_load_b2,
   output logic [16*MULTS-1:0]               dp_x,
   output logic [16*MULTS-1:0]               dp_neuron_data,
   input  logic                              dp_out_valid,
   input  logic [16*OUTPUT_NODES-1:0]        dp_y,
   output logic                              loaded,
   output logic                              busy,
   output logic                              res_valid,
   output logic [$clog2(OUTPUT_NODES)-1:0]   res_class,
   output logic [15:0]                       res_value,
   output logic                              error
);

   localparam int W1_BEATS = LAYER1_NEURONS * LAYER2_NEURONS / MULTS;
   localparam int B1_BEATS = LAYER2_NEURONS / MULTS;
   localparam int W2_BEATS = LAYER2_NEURONS * OUTPUT_NODES;
   localparam int B2_BEATS = OUTPUT_NODES;
   localparam int X_BEATS  = LAYER1_NEURONS / MULTS;
   localparam int CLS_W    = $clog2(OUTPUT_NODES);

   // One counter serves beat counting, the WAIT_OUT timeout and the scan index,
   // so it is sized for the largest of those ranges.
   localparam int MAX_A  = (W1_BEATS > W2_BEATS) ? W1_BEATS : W2_BEATS;
   localparam int MAX_B  = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
   localparam int MAX_C  = (MAX_B > OUTPUT_NODES) ? MAX_B : OUTPUT_NODES;
   localparam int CNT_W  = $clog2(MAX_C + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD_W1, S_LOAD_B1, S_LOAD_W2, S_LOAD_B2,
      S_READY, S_FEED, S_WAIT_OUT, S_SCAN, S_RESULT
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               loaded_q, loaded_d;
   logic               error_q, error_d;
   logic               res_valid_q, res_valid_d;
   logic [CLS_W-1:0]   res_class_q, res_class_d;
   logic [15:0]        res_value_q, res_value_d;
   logic               found_q, found_d;
   logic [15:0]        best_key_q, best_key_d;
   logic [CLS_W-1:0]   best_idx_q, best_idx_d;
   logic [15:0]        best_val_q, best_val_d;
   logic [15:0]        y_q [OUTPUT_NODES];
   logic [15:0]        y_d [OUTPUT_NODES];

   logic               load_state;
   logic               xfer;
   logic [CNT_W-1:0]   phase_end;
   logic               phase_last;
   logic [CLS_W-1:0]   scan_idx;
   logic [15:0]        scan_elem;
   logic               scan_nan;
   logic [15:0]        scan_key;

   assign load_state = state_q inside {S_LOAD_W1, S_LOAD_B1, S_LOAD_W2, S_LOAD_B2};
   assign s_ready    = load_state || (state_q == S_FEED);
   assign xfer       = s_valid && s_ready;
   assign busy       = !((state_q == S_IDLE) || (state_q == S_READY));

   assign dp_load_W1     = xfer && (state_q == S_LOAD_W1);
   assign dp_load_b1     = xfer && (state_q == S_LOAD_B1);
   assign dp_load_W2     = xfer && (state_q == S_LOAD_W2);
   assign dp_load_b2     = xfer && (state_q == S_LOAD_B2);
   assign dp_in_valid    = xfer && (state_q == S_FEED);
   assign dp_x           = s_data;
   assign dp_neuron_data = s_data;

   assign loaded    = loaded_q;
   assign error     = error_q;
   assign res_valid = res_valid_q;
   assign res_class = res_class_q;
   assign res_value = res_value_q;

   // Sign-magnitude fp16 mapped onto an unsigned key that orders like the
   // real values: negatives are inverted, positives get the top bit set.
   assign scan_idx  = cnt_q[CLS_W-1:0];
   assign scan_elem = y_q[scan_idx];
   assign scan_nan  = (&scan_elem[14:10]) && (|scan_elem[9:0]);
   assign scan_key  = scan_elem[15] ? ~scan_elem : (scan_elem | 16'h8000);

   always_comb begin
      phase_end = '0;
      case (state_q)
         S_LOAD_W1: phase_end = CNT_W'(W1_BEATS - 1);
         S_LOAD_B1: phase_end = CNT_W'(B1_BEATS - 1);
         S_LOAD_W2: phase_end = CNT_W'(W2_BEATS - 1);
         S_LOAD_B2: phase_end = CNT_W'(B2_BEATS - 1);
         S_FEED:    phase_end = CNT_W'(X_BEATS - 1);
         default:   phase_end = '0;
      endcase
   end

   assign phase_last = (cnt_q == phase_end);

   always_comb begin
      // NOTE: every _d starts from its _q (or a pulse default) so no path
      // through this block leaves a variable unassigned and infers a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      loaded_d    = loaded_q;
      error_d     = error_q;
      res_valid_d = 1'b0;
      res_class_d = res_class_q;
      res_value_d = res_value_q;
      found_d     = found_q;
      best_key_d  = best_key_q;
      best_idx_d  = best_idx_q;
      best_val_d  = best_val_q;
      y_d         = y_q;

      if (abort) begin
         cnt_d = '0;
         if (load_state) begin
            loaded_d = 1'b0;
            state_d  = S_IDLE;
         end else begin
            state_d = loaded_q ? S_READY : S_IDLE;
         end
      end else begin
         case (state_q)
            S_IDLE, S_READY: begin
               if (start_load) begin
                  loaded_d = 1'b0;
                  error_d  = 1'b0;
                  cnt_d    = '0;
                  state_d  = S_LOAD_W1;
               end else if (start_infer && (state_q == S_READY)) begin
                  cnt_d   = '0;
                  state_d = S_FEED;
               end
            end
            S_LOAD_W1, S_LOAD_B1, S_LOAD_W2, S_LOAD_B2, S_FEED: begin
               if (xfer) begin
                  if (phase_last) begin
                     cnt_d = '0;
                     case (state_q)
                        S_LOAD_W1: state_d = S_LOAD_B1;
                        S_LOAD_B1: state_d = S_LOAD_W2;
                        S_LOAD_W2: state_d = S_LOAD_B2;
                        S_LOAD_B2: begin
                           state_d  = S_READY;
                           loaded_d = 1'b1;
                        end
                        default:   state_d = S_WAIT_OUT;
                     endcase
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            S_WAIT_OUT: begin
               if (dp_out_valid) begin
                  for (int i = 0; i < OUTPUT_NODES; i++) begin
                     y_d[i] = dp_y[16*i +: 16];
                  end
                  // Seed the scan so an all-NaN vector reports class 0 / y[0].
                  found_d    = 1'b0;
                  best_key_d = '0;
                  best_idx_d = '0;
                  best_val_d = dp_y[15:0];
                  cnt_d      = '0;
                  state_d    = S_SCAN;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  error_d = 1'b1;
                  cnt_d   = '0;
                  state_d = S_READY;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_SCAN: begin
               // Strict greater-than keeps the lowest index on ties.
               if (!scan_nan && (!found_q || (scan_key > best_key_q))) begin
                  found_d    = 1'b1;
                  best_key_d = scan_key;
                  best_idx_d = scan_idx;
                  best_val_d = scan_elem;
               end
               if (scan_idx == CLS_W'(OUTPUT_NODES - 1)) begin
                  cnt_d   = '0;
                  state_d = S_RESULT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_RESULT: begin
               res_valid_d = 1'b1;
               res_class_d = best_idx_q;
               res_value_d = best_val_q;
               state_d     = S_READY;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         loaded_q    <= 1'b0;
         error_q     <= 1'b0;
         res_valid_q <= 1'b0;
         res_class_q <= '0;
         res_value_q <= '0;
         found_q     <= 1'b0;
         best_key_q  <= '0;
         best_idx_q  <= '0;
         best_val_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         loaded_q    <= loaded_d;
         error_q     <= error_d;
         res_valid_q <= res_valid_d;
         res_class_q <= res_class_d;
         res_value_q <= res_value_d;
         found_q     <= found_d;
         best_key_q  <= best_key_d;
         best_idx_q  <= best_idx_d;
         best_val_q  <= best_val_d;
      end
   end

   // NOTE: the y capture array carries no reset; it is always written in
   // WAIT_OUT before SCAN reads it, so a reset would only cost routing.
   always_ff @(posedge clk) begin
      y_q <= y_d;
   end

endmodule

// File: tb/tb_half_predict_sequencer.sv
module tb_half_predict_sequencer;

   localparam int L1 = 4;
   localparam int L2 = 2;
   localparam int ON = 3;
   localparam int M  = 2;
   localparam int TO = 8;
   localparam int X_BEATS = L1 / M;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              start_load = 1'b0;
   logic              start_infer = 1'b0;
   logic              abort = 1'b0;
   logic              s_valid = 1'b0;
   logic [16*M-1:0]   s_data = '0;
   logic              s_ready;
   logic              dp_in_valid;
   logic              dp_load_W1, dp_load_b1, dp_load_W2, dp_load_b2;
   logic [16*M-1:0]   dp_x;
   logic [16*M-1:0]   dp_neuron_data;
   logic              dp_out_valid = 1'b0;
   logic [16*ON-1:0]  dp_y = '0;
   logic              loaded, busy, res_valid, error;
   logic [$clog2(ON)-1:0] res_class;
   logic [15:0]       res_value;
   logic [3:0]        loads;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign loads = {dp_load_W1, dp_load_b1, dp_load_W2, dp_load_b2};

   half_predict_sequencer #(
      .LAYER1_NEURONS(L1), .LAYER2_NEURONS(L2), .OUTPUT_NODES(ON),
      .MULTS(M), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rstn(rstn), .start_load(start_load), .start_infer(start_infer),
      .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .dp_in_valid(dp_in_valid), .dp_load_W1(dp_load_W1), .dp_load_b1(dp_load_b1),
      .dp_load_W2(dp_load_W2), .dp_load_b2(dp_load_b2), .dp_x(dp_x),
      .dp_neuron_data(dp_neuron_data), .dp_out_valid(dp_out_valid), .dp_y(dp_y),
      .loaded(loaded), .busy(busy), .res_valid(res_valid), .res_class(res_class),
      .res_value(res_value), .error(error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // fp16 to real, straight from the IEEE binary16 definition.
   function automatic real h2r(input logic [15:0] h);
      int  e;
      real v;
      e = int'(h[14:10]);
      if (e == 0) begin
         v = real'(int'(h[9:0]));
         e = -24;
      end else begin
         v = real'(int'(h[9:0]) + 1024);
         e = e - 25;
      end
      while (e > 0) begin v = v * 2.0; e--; end
      while (e < 0) begin v = v / 2.0; e++; end
      return h[15] ? -v : v;
   endfunction

   // Reference argmax: largest real value, NaNs skipped, first index wins ties.
   task automatic model(input logic [16*ON-1:0] y, output int cls, output logic [15:0] val);
      bit          found;
      real         best;
      real         r;
      logic [15:0] h;
      found = 0;
      best  = 0.0;
      cls   = 0;
      val   = y[15:0];
      for (int i = 0; i < ON; i++) begin
         h = y[16*i +: 16];
         if (!(h[14:10] == 5'h1f && h[9:0] != 10'h0)) begin
            r = h2r(h);
            if (!found || r > best) begin
               found = 1;
               best  = r;
               cls   = i;
               val   = h;
            end
         end
      end
   endtask

   // Random finite non-zero fp16 value or, occasionally, a NaN.
   function automatic logic [15:0] rand_half();
      logic [15:0] h;
      h = 16'($urandom);
      if ($urandom_range(0, 5) == 0) begin
         h[14:10] = 5'h1f;
         if (h[9:0] == 10'h0) h[9] = 1'b1;
      end else begin
         h[14:10] = 5'($urandom_range(0, 30));
         if (h[14:0] == 15'h0) h[0] = 1'b1;
      end
      return h;
   endfunction

   // Parameter load; mode 0 continuous, 1 alternating valid, 2 random valid.
   // A non-zero limit stops after that many transfers, mid-load.
   task automatic do_load(input int mode, input int limit);
      int   phase_q[$];
      int   cyc;
      int   nbeats;
      logic v;
      for (int i = 0; i < L1 * L2 / M; i++) phase_q.push_back(3);
      for (int i = 0; i < L2 / M; i++)      phase_q.push_back(2);
      for (int i = 0; i < L2 * ON; i++)     phase_q.push_back(1);
      for (int i = 0; i < ON; i++)          phase_q.push_back(0);
      start_load = 1'b1;
      settle();
      tick();
      start_load = 1'b0;
      check("error_cleared_by_load", error, 0);
      cyc = 0;
      nbeats = 0;
      while (phase_q.size() > 0 && cyc < 200 && (limit == 0 || nbeats < limit)) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         s_valid = v;
         s_data  = $urandom;
         settle();
         check("s_ready_load", s_ready, 1);
         check("loaded_during_load", loaded, 0);
         check("neuron_data", dp_neuron_data, s_data);
         if (v) begin
            check("load_strobe", loads, 32'd1 << phase_q[0]);
            void'(phase_q.pop_front());
            nbeats++;
         end else begin
            check("load_strobe_stall", loads, 0);
         end
         tick();
         cyc++;
      end
      s_valid = 1'b0;
      if (limit == 0) begin
         check("load_bound", phase_q.size(), 0);
         settle();
         check("loaded_after_load", loaded, 1);
         check("busy_after_load", busy, 0);
         check("s_ready_after_load", s_ready, 0);
      end
   endtask

   // start_infer plus X_BEATS image beats; returns in the cycle after the last transfer.
   task automatic feed(input int mode);
      int   n;
      int   cyc;
      logic v;
      start_infer = 1'b1;
      settle();
      tick();
      start_infer = 1'b0;
      n = 0;
      cyc = 0;
      while (n < X_BEATS && cyc < 50) begin
         v = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         s_valid = v;
         s_data  = $urandom;
         settle();
         check("s_ready_feed", s_ready, 1);
         check("busy_feed", busy, 1);
         check("in_valid", dp_in_valid, v);
         check("dp_x", dp_x, s_data);
         check("no_load_in_feed", loads, 0);
         if (v) n++;
         tick();
         cyc++;
      end
      s_valid = 1'b0;
      check("feed_bound", n, X_BEATS);
   endtask

   task automatic infer(input logic [16*ON-1:0] y, input int lat, input int mode);
      int          exp_cls;
      logic [15:0] exp_val;
      int          waited;
      model(y, exp_cls, exp_val);
      feed(mode);
      repeat (lat - 1) begin
         settle();
         check("busy_wait", busy, 1);
         check("s_ready_wait", s_ready, 0);
         tick();
      end
      dp_y = y;
      dp_out_valid = 1'b1;
      settle();
      tick();
      dp_out_valid = 1'b0;
      dp_y = {$urandom, $urandom};
      waited = 0;
      while (res_valid !== 1'b1 && waited < 40) begin
         tick();
         waited++;
      end
      check("result_latency", waited, ON + 1);
      check("res_valid", res_valid, 1);
      check("res_class", res_class, exp_cls);
      check("res_value", res_value, exp_val);
      check("busy_at_result", busy, 0);
      tick();
      check("res_valid_one_cycle", res_valid, 0);
      check("res_class_held", res_class, exp_cls);
   endtask

   initial begin
      logic [16*ON-1:0] yv;

      // Reset state
      settle();
      check("rst_s_ready", s_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_loaded", loaded, 0);
      check("rst_error", error, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_class", res_class, 0);
      check("rst_res_value", res_value, 0);
      check("rst_loads", loads, 0);
      tick();
      tick();
      rstn = 1'b1;

      // start_infer in IDLE is ignored
      start_infer = 1'b1;
      settle();
      tick();
      start_infer = 1'b0;
      settle();
      check("infer_ignored_idle", busy, 0);

      do_load(0, 0);

      infer({16'h4000, 16'h4200, 16'hBC00}, 3, 0);
      infer({16'h3C00, 16'h7E00, 16'h3C00}, 1, 0);
      infer({16'hC200, 16'hBC00, 16'hC000}, 5, 0);
      infer({16'hFE00, 16'h7C01, 16'h7E00}, 2, 0);

      do_load(1, 0);

      // Timeout: no out_valid after feeding
      feed(0);
      for (int i = 0; i < TO; i++) begin
         settle();
         check("error_before_timeout", error, 0);
         check("busy_before_timeout", busy, 1);
         check("no_result_timeout", res_valid, 0);
         tick();
      end
      settle();
      check("error_after_timeout", error, 1);
      check("busy_after_timeout", busy, 0);
      check("loaded_after_timeout", loaded, 1);
      check("no_result_after_timeout", res_valid, 0);
      dp_out_valid = 1'b1;
      tick();
      dp_out_valid = 1'b0;
      repeat (ON + 3) begin
         check("stray_out_valid_ignored", res_valid, 0);
         check("stray_out_valid_busy", busy, 0);
         tick();
      end
      do_load(2, 0);

      for (int k = 0; k < 20; k++) begin
         for (int i = 0; i < ON; i++) yv[16*i +: 16] = rand_half();
         if ($urandom_range(0, 3) == 0) yv[16*(ON-1) +: 16] = yv[15:0];
         infer(yv, $urandom_range(1, 6), $urandom_range(0, 1));
      end

      // Abort in FEED with parameters resident returns to READY
      start_infer = 1'b1;
      settle();
      tick();
      start_infer = 1'b0;
      s_valid = 1'b1;
      s_data  = $urandom;
      settle();
      check("partial_feed_beat", dp_in_valid, 1);
      tick();
      s_valid = 1'b0;
      abort = 1'b1;
      settle();
      tick();
      abort = 1'b0;
      settle();
      check("abort_feed_busy", busy, 0);
      check("abort_feed_loaded", loaded, 1);
      check("abort_feed_s_ready", s_ready, 0);
      infer({16'h3800, 16'hB800, 16'h4400}, 2, 0);

      // start_load wins over start_infer in READY
      start_load  = 1'b1;
      start_infer = 1'b1;
      settle();
      tick();
      start_load  = 1'b0;
      start_infer = 1'b0;
      s_valid = 1'b1;
      settle();
      check("load_wins_W1", dp_load_W1, 1);
      check("load_wins_in_valid", dp_in_valid, 0);
      check("load_wins_loaded", loaded, 0);
      s_valid = 1'b0;
      abort = 1'b1;
      settle();
      tick();
      abort = 1'b0;
      settle();
      check("abort_w1_busy", busy, 0);
      check("abort_w1_loaded", loaded, 0);

      // Abort mid-W2
      do_load(0, 8);
      abort = 1'b1;
      settle();
      tick();
      abort = 1'b0;
      settle();
      check("abort_w2_busy", busy, 0);
      check("abort_w2_loaded", loaded, 0);
      check("abort_w2_s_ready", s_ready, 0);
      start_infer = 1'b1;
      settle();
      tick();
      start_infer = 1'b0;
      settle();
      check("infer_ignored_after_abort", busy, 0);

      // Async reset mid-FEED
      do_load(0, 0);
      infer({16'h4500, 16'h3C00, 16'h4100}, 1, 0);
      start_infer = 1'b1;
      settle();
      tick();
      start_infer = 1'b0;
      s_valid = 1'b1;
      s_data  = $urandom;
      settle();
      tick();
      #1;
      rstn = 1'b0;
      #1;
      check("arst_s_ready", s_ready, 0);
      check("arst_in_valid", dp_in_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_loaded", loaded, 0);
      check("arst_res_class", res_class, 0);
      check("arst_res_value", res_value, 0);
      check("arst_error", error, 0);
      check("arst_loads", loads, 0);
      s_valid = 1'b0;
      tick();
      rstn = 1'b1;
      start_infer = 1'b1;
      settle();
      tick();
      start_infer = 1'b0;
      settle();
      check("infer_ignored_after_reset", busy, 0);
      check("s_ready_after_reset", s_ready, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/half_predict_sequencer.md
Name: half_predict_sequencer

Overview:
- Top-level controller for the half-precision two-layer predictor datapath.
- Accepts one host stream carrying beats of MULTS half-precision lanes. Routes weight/bias beats to the datapath load strobes in a fixed order: W1, b1, W2, b2.
- Feeds image beats as x with in_valid, waits for the datapath out_valid, captures y, and reports the argmax class.
- Sits between the host/DMA adapter and the predictor datapath.

Parameters:
- LAYER1_NEURONS, 784, inputs per image.
- LAYER2_NEURONS, 50, hidden neurons.
- OUTPUT_NODES, 10, output classes.
- MULTS, 2, lanes per beat (datapath layer-1 multiplier count). Must divide LAYER1_NEURONS and LAYER2_NEURONS.
- TIMEOUT, 65535, maximum cycles in WAIT_OUT before error.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start_load  in  1  pulse: begin weight/bias load (accepted only in IDLE or READY)
- start_infer  in  1  pulse: begin one inference (accepted only in READY)
- abort  in  1  synchronous abort to IDLE
- s_valid  in  1  host beat valid
- s_data  in  16×MULTS  host beat lanes
- s_ready  out  1  sequencer accepts beat
- dp_in_valid  out  1  to datapath in_valid
- dp_load_W1 / dp_load_b1 / dp_load_W2 / dp_load_b2  out  1 each  datapath load strobes
- dp_x  out  16×MULTS  to datapath x
- dp_neuron_data  out  16×MULTS  to datapath neuron_data_in
- dp_out_valid  in  1  datapath out_valid
- dp_y  in  16×OUTPUT_NODES  datapath y
- loaded  out  1  full parameter set resident
- busy  out  1  state not IDLE/READY
- res_valid  out  1  one-cycle result pulse
- res_class  out  $clog2(OUTPUT_NODES)  argmax index
- res_value  out  16  y value at argmax
- error  out  1  sticky timeout flag; cleared by start_load or reset

Behaviour:
- Reset: state IDLE; all outputs 0; beat counter 0; loaded 0; error 0.
- Beat counts:
  - W1 = LAYER1_NEURONS·LAYER2_NEURONS/MULTS
  - B1 = LAYER2_NEURONS/MULTS
  - W2 = LAYER2_NEURONS·OUTPUT_NODES
  - B2 = OUTPUT_NODES
  - X = LAYER1_NEURONS/MULTS
  - W2 and B2 beats use lane 0 only; other lanes are ignored.
- States: IDLE, LOAD_W1, LOAD_B1, LOAD_W2, LOAD_B2, READY, FEED, WAIT_OUT, SCAN, RESULT.
- s_ready = 1 only in LOAD_* and FEED. A transfer occurs when s_valid & s_ready.
- dp_neuron_data and dp_x are combinational copies of s_data.
- In LOAD_x, the matching dp_load_x = transfer, asserted on exactly the transfer cycles; there are no bubbles on the datapath side.
- Each transfer increments the counter. On the last beat of a phase: counter → 0 and advance to the next phase. Last B2 beat → READY and loaded ← 1.
- start_load in IDLE/READY: loaded ← 0, error ← 0, → LOAD_W1. Transfer begins the following cycle.
- start_infer in READY → FEED. start_infer in any other state is ignored. start_load and start_infer together in READY: start_load wins.
- FEED: dp_in_valid = transfer. Last X beat → WAIT_OUT with the timeout counter cleared.
- WAIT_OUT: on dp_out_valid, register all dp_y and → SCAN. If the timeout counter reaches TIMEOUT first: error ← 1 and → READY with no result. dp_out_valid outside WAIT_OUT is ignored.
- SCAN: one element per cycle, index 0..OUTPUT_NODES−1, so OUTPUT_NODES cycles.
  - Order key = bits[15] ? ~bits : bits|16'h8000.
  - Strict greater-than, so ties keep the lowest index.
  - NaN entries (exp=31, mantissa≠0) are skipped. If all are NaN: class 0, value = y[0].
- RESULT: res_valid = 1 for one cycle; res_class/res_value held until the next RESULT. → READY.
- Latency: from last X transfer to res_valid = (datapath latency) + OUTPUT_NODES + 2 cycles.
- abort (any state, has priority over all): → IDLE next cycle; counters cleared. If aborted in LOAD_*: loaded ← 0. Otherwise loaded is unchanged and abort returns to READY instead of IDLE if loaded=1.
- s_valid low mid-phase stalls the counter; no timeout applies during LOAD/FEED.
- Async reset mid-operation: immediate return to reset values; the datapath weights are then considered invalid (loaded=0).

Test Plan:
- Load sequence (L1=4, L2=2, OUT=3, MULTS=2): start_load, 14 continuous beats → dp_load_W1 high for 4 cycles, b1 for 1, W2 for 6, b2 for 3; loaded=1 the cycle after the 14th transfer; state READY.
- Stalled load: s_valid toggled 1,0,1,0 across the W1 phase → dp_load_W1 asserted only on valid cycles; exactly 4 W1 strobes; no early phase change.
- Inference: start_infer, 2 beats, dp_out_valid with y={16'hBC00 (−1.0), 16'h4200 (3.0), 16'h4000 (2.0)} → res_class=1, res_value=16'h4200, res_valid one cycle.
- Ties and NaN: y={16'h3C00, 16'h7E00, 16'h3C00} → res_class=0, res_value=16'h3C00. Negatives only, y={16'hC000, 16'hBC00, 16'hC200} → res_class=1.
- Timeout (TIMEOUT=8): no dp_out_valid after feed → error=1 after 8 cycles, state READY, no res_valid; start_load clears error.
- Abort mid-W2 → IDLE, loaded=0, s_ready=0. Async rstn low mid-FEED → all outputs 0 immediately; start_infer afterwards ignored.
